booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//  Sequencer for the radix-4 Booth partial-product recoder (8x8 signed).
//  - Accepts one multiply request (a x b) at a time.
//  - Issues the 4 Booth groups of multiplier a to the recoder on consecutive cycles.
//  - Drives the matching shift code (extend) skewed one cycle behind each group.
//  - Accumulates the 14-bit partial products into a 16-bit signed product.
//  - Reports completion with start/busy/done.
// PARAMETERS
//  PP_LAT    3  cycles from rec_opr presented to rec_pp valid for that group (legal 3..6)
//  EXT_SKEW  1  cycles rec_ext lags its rec_opr (fixed by recoder, do not change)
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   synchronous active-high reset
//  start    in   1   request; accepted only in IDLE
//  a        in   8   signed multiplier (Booth-recoded), sampled on accept
//  b        in   8   signed multiplicand, sampled on accept
//  busy     out  1   high in ISSUE/DRAIN
//  done     out  1   one-cycle pulse, product valid
//  product  out  16  signed a*b, held until next accept
//  ovf      out  1   partial product not representable in recoder's 8-bit pp, valid with done
//  rec_opr  out  3   Booth group to recoder
//  rec_ext  out  2   shift code to recoder (group index i -> shift 2i)
//  rec_b    out  8   multiplicand to recoder
//  rec_pp   in   14  partial product from recoder
// BEHAVIOUR
//  Reset values: busy=0, done=0, product=0, ovf=0, rec_opr=000, rec_ext=00, rec_b=0, FSM=IDLE.
//  Groups: g_i = {a[2i+1], a[2i], a[2i-1]}, i=0..3, with a[-1]=0.
//  FSM states:
//   - IDLE: start=1 latches a, b; clears acc and ovf -> ISSUE, cnt=0.
//   - ISSUE: rec_opr=g_cnt; cnt++; after cnt=3 -> DRAIN.
//   - DRAIN: wait until the group-3 pp is accumulated -> DONE.
//   - DONE: done=1 for one cycle -> IDLE.
//  Outside ISSUE, rec_opr=000, so the recoder produces a zero pp.
//  rec_b holds the latched b from accept until DONE.
//  Skew: rec_ext equals i in the cycle after g_i is on rec_opr, i.e. EXT_SKEW cycles later.
//  Accumulate: a valid/tag shift register of depth PP_LAT tracks issued groups. When a tag
//   emerges: acc <= acc + sign-extend(rec_pp, 16). Untagged rec_pp is ignored.
//  Arithmetic: acc and product are 16-bit two's complement; the sum is exact when ovf=0.
//  Timing (PP_LAT=3), start accepted in cycle 0:
//   - g0..g3 issued in cycles 1..4.
//   - Accumulates at the ends of cycles 4..7.
//   - done=1 and product valid in cycle 8. Latency 8 = PP_LAT+5.
//  ovf is set if any issued group needs a pp outside [-128,127]:
//   - 011 with b outside [-64,63]
//   - 100 with b outside [-63,64]
//   - 101/110 with b=-128
//  When ovf=1, product is undefined.
//  start while busy or in DONE: ignored, no queueing.
//  A new start is accepted from the IDLE cycle after DONE (back-to-back spacing 9 cycles).
//  rst mid-operation: return to IDLE next edge; all outputs go to reset values.
//   In-flight tags are flushed; rec_pp arriving afterwards is ignored.
//  a/b changes after accept: no effect on the current operation.
// TESTING
//  1. a=3, b=5, start in cycle 0 -> rec_opr 110,001,000,000 in cycles 1-4; done cycle 8; product=15; ovf=0.
//  2. a=-128, b=1 -> groups 000,000,000,100; product=-128; ovf=0.
//  3. a=-1, b=-1 -> product=1; ovf=0.
//     a=1, b=-128 -> product=-128; ovf=0.
//     a=-1, b=-128 -> ovf=1 at done.
//  4. Exhaustive a,b in [-63,63] vs reference a*b; start on the cycle after every DONE
//     -> all match, ovf=0, done spacing 9.
//  5. start pulsed in cycles 3 and 8 (busy/DONE) -> ignored, exactly one done.
//     Next start in cycle 9 -> accepted.
//  6. rst in cycle 5 of a=7, b=9 -> idle outputs next cycle, no done.
//     Then a=2, b=3 -> product=6 (no residue from the aborted operation).

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
//   Sequencer for an external radix-4 Booth partial-product recoder (8x8 signed).
//   Accepts one multiply request at a time and issues the four Booth groups of
//   the multiplier on consecutive cycles. The matching shift code follows one
//   cycle behind each group. The 14-bit partial products that come back are
//   summed into a 16-bit signed product.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_start     request, accepted only in IDLE
//   i_a         signed multiplier (Booth-recoded), sampled on accept
//   i_b         signed multiplicand, sampled on accept
//   o_busy      high in ISSUE/DRAIN
//   o_done      one-cycle pulse, product valid
//   o_product   signed a*b, held until next accept
//   o_ovf       some issued group needs a pp outside the recoder's 8-bit range
//   o_rec_opr   Booth group to recoder (000 outside ISSUE -> zero pp)
//   o_rec_ext   shift code to recoder (group i -> shift 2i), one cycle after the group
//   o_rec_b     latched multiplicand to recoder
//   i_rec_pp    partial product from recoder, PpLat cycles after its group

module booth_seq_ctrl #(
  parameter int unsigned PpLat = 3  // legal 3..6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product,
  output logic        o_ovf,
  output logic [2:0]  o_rec_opr,
  output logic [1:0]  o_rec_ext,
  output logic [7:0]  o_rec_b,
  input  logic [13:0] i_rec_pp
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      r_acc;
  logic             r_ovf;
  logic [1:0]       r_ext;
  logic [PpLat-1:0] r_tag;

  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_issue;
  logic [8:0]  w_a_ext;
  logic [2:0]  w_grp;
  logic [8:0]  w_b_neg;
  logic        w_grp_ovf;
  logic        w_tag_out;
  logic        w_tag_pending;
  logic [15:0] w_pp_ext;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_issue  = (r_state == StIssue);

  // a[-1] = 0 is appended below the LSB.
  assign w_a_ext = {r_a, 1'b0};

  always_comb begin
    w_grp = 3'b000;
    unique case (r_cnt)
      2'd0: w_grp = w_a_ext[2:0];
      2'd1: w_grp = w_a_ext[4:2];
      2'd2: w_grp = w_a_ext[6:4];
      2'd3: w_grp = w_a_ext[8:6];
      default: w_grp = 3'b000;
    endcase
  end

  // -b in 9 bits; -2b fits 8 bits iff -b fits 7 bits (top three bits equal).
  assign w_b_neg = 9'd0 - {r_b[7], r_b};

  always_comb begin
    w_grp_ovf = 1'b0;
    case (w_grp)
      3'b011:          w_grp_ovf = (r_b[7] != r_b[6]);
      3'b100:          w_grp_ovf = !((w_b_neg[8:6] == 3'b000) || (w_b_neg[8:6] == 3'b111));
      3'b101, 3'b110:  w_grp_ovf = (r_b == 8'h80);
      default:         w_grp_ovf = 1'b0;
    endcase
  end

  // A tag leaving the last stage marks rec_pp as belonging to an issued group.
  assign w_tag_out     = r_tag[PpLat-1];
  assign w_tag_pending = |r_tag[PpLat-2:0];
  assign w_pp_ext      = {{2{i_rec_pp[13]}}, i_rec_pp};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_nxt = StIssue;
      StIssue: if (r_cnt == 2'd3) w_state_nxt = StDrain;
      // Last group's pp is being summed when its tag leaves with none behind it.
      StDrain: if (w_tag_out && !w_tag_pending) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_acc   <= 16'd0;
      r_ovf   <= 1'b0;
      r_ext   <= 2'd0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= {r_tag[PpLat-2:0], w_issue};
      r_ext   <= w_issue ? r_cnt : 2'd0;
      if (w_accept) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= 16'd0;
        r_ovf <= 1'b0;
        r_cnt <= 2'd0;
      end else begin
        if (w_issue) begin
          r_cnt <= r_cnt + 2'd1;
          if (w_grp_ovf) r_ovf <= 1'b1;
        end
        if (w_tag_out) r_acc <= r_acc + w_pp_ext;
      end
    end
  end

  assign o_busy    = (r_state == StIssue) || (r_state == StDrain);
  assign o_done    = (r_state == StDone);
  assign o_product = r_acc;
  assign o_ovf     = r_ovf;
  assign o_rec_opr = w_issue ? w_grp : 3'b000;
  assign o_rec_ext = r_ext;
  assign o_rec_b   = r_b;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [2:0]  rec_opr;
  logic [1:0]  rec_ext;
  logic [7:0]  rec_b;
  logic [13:0] rec_pp;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  booth_seq_ctrl dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product),
    .o_ovf     (ovf),
    .o_rec_opr (rec_opr),
    .o_rec_ext (rec_ext),
    .o_rec_b   (rec_b),
    .i_rec_pp  (rec_pp)
  );

  function automatic int digit(input logic [2:0] g);
    case (g)
      3'b001, 3'b010: return 1;
      3'b011:         return 2;
      3'b100:         return -2;
      3'b101, 3'b110: return -1;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [2:0] grp(input logic [7:0] av, input int i);
    logic [8:0] x;
    x = {av, 1'b0};
    return x[2*i +: 3];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] av, input logic [7:0] bv);
    int p;
    for (int i = 0; i < 4; i++) begin
      p = digit(grp(av, i)) * int'($signed(bv));
      if (p < -128 || p > 127) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Recoder model: digit*b one cycle after the group, shifted by the code that
  // arrives the next cycle, valid three cycles after the group. Never reset.
  int s1 = 0;
  int s2 = 0;
  int s3 = 0;
  always @(posedge clk) begin
    s1 <= digit(rec_opr) * int'($signed(rec_b));
    s2 <= s1 * (1 << (2 * int'(rec_ext)));
    s3 <= s2;
  end
  assign rec_pp = s3[13:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    logic signed [15:0] p;
    p = $signed(av) * $signed(bv);
    e.prod = p;
    e.ovf  = ref_ovf(av, bv);
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      if (!e.ovf) check("product", {16'd0, product}, {16'd0, e.prod});
      check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
    end
  endtask

  // Called in cycle 0 of the operation; returns in cycle 9 (the IDLE cycle after DONE).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit chk_seq);
    int lat;
    push_exp(av, bv);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 1;
    if (chk_seq) begin
      for (int g = 0; g < 4; g++) begin
        check("rec_opr", {29'd0, rec_opr}, {29'd0, grp(av, g)});
        check("busy", {31'd0, busy}, 32'd1);
        check("rec_b", {24'd0, rec_b}, {24'd0, bv});
        tick();
        lat++;
        check("rec_ext", {30'd0, rec_ext}, g);
      end
    end
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("done_lat", lat, 32'd8);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    pop_cmp();
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_rec_opr", {29'd0, rec_opr}, 32'd0);
    check("rst_rec_ext", {30'd0, rec_ext}, 32'd0);
    check("rst_rec_b", {24'd0, rec_b}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases, including the 8-bit corners.
    run_op(8'd3, 8'd5, 1'b1);
    run_op(8'h80, 8'd1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'd1, 8'h80, 1'b1);
    run_op(8'hFF, 8'h80, 1'b1);
    run_op(8'd127, 8'd127, 1'b1);
    run_op(8'h80, 8'd64, 1'b1);
    run_op(8'd2, 8'hC0, 1'b1);

    // Strided sweep over [-63,63], each start on the cycle after DONE.
    for (int ai = -63; ai <= 63; ai += 9) begin
      for (int bi = -63; bi <= 63; bi += 7) begin
        run_op(8'(ai), 8'(bi), 1'b0);
      end
    end

    // Starts during busy (cycle 3) and DONE (cycle 8) must be ignored.
    push_exp(8'd5, 8'd6);
    a = 8'd5;
    b = 8'd6;
    start = 1'b1;
    n_done = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      start = (cyc == 3 || cyc == 8);
      a = 8'd11;
      b = 8'hFD;
      if (done === 1'b1) begin
        n_done++;
        pop_cmp();
      end
    end
    tick();
    start = 1'b0;
    if (done === 1'b1) n_done++;
    check("ignored_start_busy", {31'd0, busy}, 32'd0);
    check("one_done", n_done, 32'd1);
    run_op(8'hFC, 8'd7, 1'b0);

    // Reset in cycle 5 aborts; the next operation sees no residue.
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 5; cyc++) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    check("abort_rec_opr", {29'd0, rec_opr}, 32'd0);
    check("abort_rec_ext", {30'd0, rec_ext}, 32'd0);
    check("abort_rec_b", {24'd0, rec_b}, 32'd0);
    rst = 1'b0;
    run_op(8'd2, 8'd3, 1'b1);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
